// File: rtl/mem_window_sequencer.sv
// Walks every kernel window of an IMAGE_WIDTH x IMAGE_HEIGHT image in batches of
// NUM_UNITS windows. Optional busy_cycles counter: MEM_WINDOW_SEQUENCER_PERF_EN.
module mem_window_sequencer #(
    parameter int IMAGE_WIDTH  = 8,
    parameter int IMAGE_HEIGHT = 8,
    parameter int NUM_UNITS    = 2,
    parameter int AW           = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT),
    parameter int KW           = (IMAGE_WIDTH > 1) ? $clog2(IMAGE_WIDTH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [KW-1:0]           kernel_dim,
    input  logic                    hold,
    output logic                    en,
    output logic                    step,
    output logic [NUM_UNITS*AW-1:0] start_addr_1,
    output logic [NUM_UNITS*AW-1:0] start_addr_2,
    output logic [NUM_UNITS*AW-1:0] out_addr,
    output logic [NUM_UNITS-1:0]    unit_mask,
    output logic                    batch_valid,
    output logic                    busy,
    output logic                    done,
    output logic                    err,
    output logic [15:0]             busy_cycles,
    output logic [2:0]              fsm_state
);

    // Handshake: start is a level sampled only in IDLE; en, step, batch_valid,
    // done and err are single-cycle pulses; hold is the only back-pressure and
    // it freezes stepping without disturbing the batch outputs.

    localparam int CW      = AW + 1;
    localparam int SW      = 2 * KW;
    localparam int UW      = NUM_UNITS * AW;
    localparam int MIN_DIM = (IMAGE_WIDTH < IMAGE_HEIGHT) ? IMAGE_WIDTH : IMAGE_HEIGHT;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_STEP  = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [KW-1:0]   kd_q;
    logic [SW-1:0]   kd_sq_q;
    logic [SW-1:0]   step_cnt;
    logic [CW-1:0]   row_q;
    logic [CW-1:0]   col_q;
    logic [CW-1:0]   org_base_q;
    logic [CW-1:0]   out_base_q;
    logic [UW-1:0]   org_q;
    logic [UW-1:0]   out_q;
    logic [NUM_UNITS-1:0] mask_q;
    logic            err_q;

    logic            kd_ok;
    logic            accept;
    logic [KW-1:0]   kd_sel;
    logic [CW-1:0]   ow;
    logic [CW-1:0]   oh;
    logic [CW-1:0]   r;
    logic [CW-1:0]   c;
    logic [CW-1:0]   ob;
    logic [CW-1:0]   qb;
    logic [UW-1:0]   nb_org;
    logic [UW-1:0]   nb_out;
    logic [NUM_UNITS-1:0] nb_mask;

    assign kd_ok  = (kernel_dim != '0) && (int'(kernel_dim) <= MIN_DIM);
    assign accept = (state == S_IDLE) && start && kd_ok;

    // Next batch: walk the raster from the current counters (or from the origin
    // when a pass is being accepted), one window per unit, no dividers.
    always_comb begin
        kd_sel  = (state == S_IDLE) ? kernel_dim : kd_q;
        ow      = CW'(IMAGE_WIDTH) - CW'(kd_sel) + CW'(1);
        oh      = CW'(IMAGE_HEIGHT) - CW'(kd_sel) + CW'(1);
        r       = (state == S_IDLE) ? '0 : row_q;
        c       = (state == S_IDLE) ? '0 : col_q;
        ob      = (state == S_IDLE) ? '0 : org_base_q;
        qb      = (state == S_IDLE) ? '0 : out_base_q;
        nb_org  = '0;
        nb_out  = '0;
        nb_mask = '0;
        for (int u = 0; u < NUM_UNITS; u++) begin
            if (r < oh) begin
                nb_org[u*AW +: AW] = AW'(ob + c);
                nb_out[u*AW +: AW] = AW'(qb + c);
                nb_mask[u]         = 1'b1;
                if (c == ow - CW'(1)) begin
                    c  = '0;
                    r  = r + CW'(1);
                    ob = ob + CW'(IMAGE_WIDTH);
                    qb = qb + ow;
                end else begin
                    c = c + CW'(1);
                end
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (accept) state_next = S_LOAD;
            S_LOAD:  state_next = S_STEP;
            S_STEP:  if (!hold && (step_cnt == kd_sq_q - SW'(1))) state_next = S_FLUSH;
            // Counters already point past this batch, so only the test remains.
            S_FLUSH: state_next = (row_q < oh) ? S_LOAD : S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            kd_q       <= '0;
            kd_sq_q    <= '0;
            step_cnt   <= '0;
            row_q      <= '0;
            col_q      <= '0;
            org_base_q <= '0;
            out_base_q <= '0;
            org_q      <= '0;
            out_q      <= '0;
            mask_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state <= state_next;
            err_q <= (state == S_IDLE) && start && !kd_ok;
            if (accept) begin
                kd_q    <= kernel_dim;
                kd_sq_q <= SW'(kernel_dim) * SW'(kernel_dim);
            end
            if (state_next == S_LOAD) begin
                org_q      <= nb_org;
                out_q      <= nb_out;
                mask_q     <= nb_mask;
                row_q      <= r;
                col_q      <= c;
                org_base_q <= ob;
                out_base_q <= qb;
                step_cnt   <= '0;
            end else if ((state == S_STEP) && !hold) begin
                step_cnt <= step_cnt + SW'(1);
            end
            if (state_next == S_DONE) begin
                org_q  <= '0;
                out_q  <= '0;
                mask_q <= '0;
            end
        end
    end

    assign en           = (state == S_LOAD);
    assign step         = (state == S_STEP) && !hold;
    assign batch_valid  = (state == S_FLUSH);
    assign done         = (state == S_DONE);
    assign busy         = (state != S_IDLE);
    assign err          = err_q;
    assign start_addr_1 = org_q;
    assign start_addr_2 = '0;
    assign out_addr     = out_q;
    assign unit_mask    = mask_q;
    assign fsm_state    = state;

`ifdef MEM_WINDOW_SEQUENCER_PERF_EN
    logic [15:0] perf_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else if (accept) begin
            perf_q <= '0;
        end else if (busy && (perf_q != 16'hFFFF)) begin
            perf_q <= perf_q + 16'd1;
        end
    end

    assign busy_cycles = perf_q;
`else
    assign busy_cycles = '0;
`endif

endmodule

// File: tb/tb_mem_window_sequencer.sv
// Bench for mem_window_sequencer: directed passes with randomized hold and
// stray starts, checked cycle by cycle against a window-list model.
module tb_mem_window_sequencer;

    localparam int IW = 8;
    localparam int IH = 8;
    localparam int NU = 2;
    localparam int AW = 6;
    localparam int KW = 3;
    localparam int UW = NU * AW;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [KW-1:0] kernel_dim;
    logic          hold;
    logic          en;
    logic          step;
    logic [UW-1:0] start_addr_1;
    logic [UW-1:0] start_addr_2;
    logic [UW-1:0] out_addr;
    logic [NU-1:0] unit_mask;
    logic          batch_valid;
    logic          busy;
    logic          done;
    logic          err;
    logic [15:0]   busy_cycles;
    logic [2:0]    fsm_state;

    int checks   = 0;
    int failures = 0;

    logic [UW-1:0] first_org;
    logic [UW-1:0] first_out;
    logic [UW-1:0] last_org;
    logic [UW-1:0] last_out;
    logic [NU-1:0] last_mask;

    always #5 clk = ~clk;

    mem_window_sequencer #(
        .IMAGE_WIDTH (IW),
        .IMAGE_HEIGHT(IH),
        .NUM_UNITS   (NU),
        .AW          (AW),
        .KW          (KW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .kernel_dim  (kernel_dim),
        .hold        (hold),
        .en          (en),
        .step        (step),
        .start_addr_1(start_addr_1),
        .start_addr_2(start_addr_2),
        .out_addr    (out_addr),
        .unit_mask   (unit_mask),
        .batch_valid (batch_valid),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .busy_cycles (busy_cycles),
        .fsm_state   (fsm_state)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle(input string tag, input bit e_en, input bit e_step,
                               input bit e_bv, input bit e_done, input bit e_busy,
                               input bit chk_addr, input logic [UW-1:0] e_org,
                               input logic [UW-1:0] e_out, input logic [NU-1:0] e_mask);
        chk({tag, "_en"}, en, e_en);
        chk({tag, "_step"}, step, e_step);
        chk({tag, "_bv"}, batch_valid, e_bv);
        chk({tag, "_done"}, done, e_done);
        chk({tag, "_busy"}, busy, e_busy);
        chk({tag, "_err"}, err, 1'b0);
        chk({tag, "_sa2"}, start_addr_2, '0);
        chk({tag, "_en_step_excl"}, en & step, 1'b0);
        if (chk_addr) begin
            chk({tag, "_sa1"}, start_addr_1, e_org);
            chk({tag, "_oaddr"}, out_addr, e_out);
            chk({tag, "_mask"}, unit_mask, e_mask);
        end
    endtask

    // One pass of kernel side kd. hold_mode: 0 none, 1 random, 2 three cycles
    // in the first batch. abort_batch >= 0 resets the DUT inside that batch.
    task automatic run_pass(input int kd, input int hold_mode, input bit busy_start,
                            input int abort_batch);
        logic [AW-1:0] exp_org_q[$];
        logic [AW-1:0] exp_out_q[$];
        logic [UW-1:0] e_org;
        logic [UW-1:0] e_out;
        logic [NU-1:0] e_mask;
        logic [15:0]   exp_perf;
        int ow, oh, nb, holds, steps, scyc;
        bit h;
        ow = IW - kd + 1;
        oh = IH - kd + 1;
        for (int rr = 0; rr < oh; rr++) begin
            for (int cc = 0; cc < ow; cc++) begin
                exp_org_q.push_back(AW'(rr * IW + cc));
                exp_out_q.push_back(AW'(rr * ow + cc));
            end
        end
        nb    = (exp_org_q.size() + NU - 1) / NU;
        holds = 0;

        start      = 1'b1;
        kernel_dim = KW'(kd);
        hold       = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;

        for (int b = 0; b < nb; b++) begin
            e_org  = '0;
            e_out  = '0;
            e_mask = '0;
            for (int u = 0; u < NU; u++) begin
                if (exp_org_q.size() > 0) begin
                    e_org[u*AW +: AW] = exp_org_q.pop_front();
                    e_out[u*AW +: AW] = exp_out_q.pop_front();
                    e_mask[u]         = 1'b1;
                end
            end
            #1;
            check_cycle($sformatf("load_k%0d_b%0d", kd, b), 1, 0, 0, 0, 1, 1, e_org, e_out, e_mask);
            if (b == 0) begin
                first_org = start_addr_1;
                first_out = out_addr;
            end
            if (b == nb - 1) begin
                last_org  = start_addr_1;
                last_out  = out_addr;
                last_mask = unit_mask;
            end
            @(posedge clk); #1;

            steps = 0;
            scyc  = 0;
            while (steps < kd * kd) begin
                if (hold_mode == 1) h = ($urandom_range(0, 3) == 0);
                else if (hold_mode == 2) h = (b == 0) && (scyc >= 1) && (scyc <= 3);
                else h = 1'b0;
                hold = h;
                if (busy_start) begin
                    start      = 1'($urandom_range(0, 1));
                    kernel_dim = KW'($urandom_range(0, 7));
                end
                if (b == abort_batch && scyc == 2) begin
                    hold  = 1'b0;
                    start = 1'b0;
                    reset = 1'b1;
                    @(posedge clk); #1;
                    reset = 1'b0;
                    #1;
                    check_cycle("after_reset", 0, 0, 0, 0, 0, 1, '0, '0, '0);
                    chk("after_reset_busy_cycles", busy_cycles, 16'd0);
                    return;
                end
                #1;
                check_cycle($sformatf("step_k%0d_b%0d_c%0d", kd, b, scyc), 0, !h, 0, 0, 1, 1,
                            e_org, e_out, e_mask);
                if (h) holds++;
                else steps++;
                scyc++;
                @(posedge clk); #1;
            end

            hold  = 1'b0;
            start = 1'b0;
            #1;
            check_cycle($sformatf("flush_k%0d_b%0d", kd, b), 0, 0, 1, 0, 1, 1, e_org, e_out, e_mask);
            @(posedge clk); #1;
        end

        #1;
        check_cycle($sformatf("done_k%0d", kd), 0, 0, 0, 1, 1, 0, '0, '0, '0);
        @(posedge clk); #1;
        #1;
        check_cycle($sformatf("idle_k%0d", kd), 0, 0, 0, 0, 0, 0, '0, '0, '0);
`ifdef MEM_WINDOW_SEQUENCER_PERF_EN
        exp_perf = 16'(nb * (kd * kd + 2) + holds + 1);
`else
        exp_perf = 16'd0;
`endif
        chk($sformatf("busy_cycles_k%0d", kd), busy_cycles, exp_perf);
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        hold       = 1'b0;
        kernel_dim = '0;
        repeat (3) @(posedge clk);
        #1;
        #1;
        check_cycle("reset", 0, 0, 0, 0, 0, 1, '0, '0, '0);
        chk("reset_busy_cycles", busy_cycles, 16'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Full pass kd=3: 18 batches of 11 cycles, done at cycle 199.
        run_pass(3, 0, 0, -1);
        chk("kd3_first_sa1", first_org, {6'd1, 6'd0});
        chk("kd3_first_oaddr", first_out, {6'd1, 6'd0});
        chk("kd3_last_sa1", last_org, {6'd45, 6'd44});
        chk("kd3_last_oaddr", last_out, {6'd35, 6'd34});

        // Partial final batch, kd=4.
        run_pass(4, 0, 0, -1);
        chk("kd4_last_mask", last_mask, 2'b01);
        chk("kd4_last_sa1", last_org, {6'd0, 6'd36});
        chk("kd4_last_oaddr", last_out, {6'd0, 6'd24});

        // Three hold cycles inside the first STEP phase, kd=2.
        run_pass(2, 2, 0, -1);

        // Rejected start.
        start      = 1'b1;
        kernel_dim = '0;
        @(posedge clk); #1;
        start = 1'b0;
        #1;
        chk("bad_start_err", err, 1'b1);
        chk("bad_start_busy", busy, 1'b0);
        chk("bad_start_en", en, 1'b0);
        @(posedge clk); #1;
        #1;
        chk("bad_start_err_clear", err, 1'b0);
        chk("bad_start_busy_after", busy, 1'b0);

        // Random holds plus stray starts while busy.
        run_pass(3, 1, 1, -1);

        // Reset inside batch 5, then a fresh full pass.
        run_pass(3, 0, 0, 4);
        run_pass(3, 0, 0, -1);
        chk("post_reset_last_sa1", last_org, {6'd45, 6'd44});

        for (int i = 0; i < 4; i++) begin
            run_pass($urandom_range(1, 7), 1, 1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
